// File: rtl/frontend_rr_arbiter_if.sv
// Handshake bundle between the per-core requesters / DRAM controller and the
// frontend round-robin arbiter.
//   in_valid  [NUM_CORES]        per-core request valid
//   in_ready  [NUM_CORES]        per-core FIFO can accept
//   in_req    [NUM_CORES*REQ_W]  per-core request, core k at [k*REQ_W +: REQ_W]
//   out_valid                    registered request available
//   out_ready                    controller accepts out_req this cycle
//   out_req   [REQ_W]            granted request, core_num = source port index
//   out_grant [NUM_CORES]        one-hot source of out_req, 0 when idle
//   fifo_full [NUM_CORES]        per-core FIFO full status
// master: requesters + controller side.  slave: the arbiter.
interface frontend_rr_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int REQ_W     = 37
);
  logic [NUM_CORES-1:0]       in_valid;
  logic [NUM_CORES-1:0]       in_ready;
  logic [NUM_CORES*REQ_W-1:0] in_req;
  logic                       out_valid;
  logic                       out_ready;
  logic [REQ_W-1:0]           out_req;
  logic [NUM_CORES-1:0]       out_grant;
  logic [NUM_CORES-1:0]       fifo_full;

  modport master (
    output in_valid, in_req, out_ready,
    input  in_ready, out_valid, out_req, out_grant, fifo_full
  );

  modport slave (
    input  in_valid, in_req, out_ready,
    output in_ready, out_valid, out_req, out_grant, fifo_full
  );
endinterface

// File: rtl/frontend_rr_arbiter.sv
// Frontend round-robin arbiter: shares the single command path into the DRAM
// global controller between NUM_CORES requesters. Each core pushes into a
// private circular FIFO; a round-robin search pops one entry per cycle into a
// registered output stage. The core_num tag of the outgoing request is
// overwritten with the physical port index so response routing never depends
// on requester-supplied tags.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  frontend_rr_arbiter_if.slave (in_valid/in_ready/in_req per core,
//        out_valid/out_ready/out_req/out_grant, fifo_full)
// Request layout MSB..LSB: op_type, data_type[1:0], row, col, bank,
// req_id[4:0], core_num[1:0].
module frontend_rr_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_BITS   = 14,
  parameter int COL_BITS   = 10,
  parameter int BANK_BITS  = 3,
  parameter int REQ_W      = 1 + 2 + ROW_BITS + COL_BITS + BANK_BITS + 5 + 2
) (
  input logic                  clk,
  input logic                  rst,
  frontend_rr_arbiter_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(NUM_CORES);

  // Per-core storage and pointers. Pointers carry one extra wrap bit above the
  // index so a full FIFO (same index, different wrap) is distinct from empty.
  logic [REQ_W-1:0] r_mem  [NUM_CORES][FIFO_DEPTH];
  logic [AW:0]      r_wptr [NUM_CORES];
  logic [AW:0]      r_rptr [NUM_CORES];

  logic [CW-1:0]        r_ptr;
  logic                 r_out_valid;
  logic [REQ_W-1:0]     r_out_req;
  logic [NUM_CORES-1:0] r_out_grant;

  logic [NUM_CORES-1:0] w_empty;
  logic [NUM_CORES-1:0] w_full;
  logic [NUM_CORES-1:0] w_in_ready;
  logic [NUM_CORES-1:0] w_push;
  logic [NUM_CORES-1:0] w_pop;
  logic [NUM_CORES-1:0] w_grant;
  logic                 w_found;
  logic [CW-1:0]        w_win;
  logic                 w_load;
  logic [REQ_W-1:0]     w_head;
  logic [REQ_W-1:0]     w_stamped;

  always_comb begin
    w_empty = '0;
    w_full  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_empty[k] = (r_wptr[k] == r_rptr[k]);
      w_full[k]  = (r_wptr[k][AW] != r_rptr[k][AW]) &&
                   (r_wptr[k][AW-1:0] == r_rptr[k][AW-1:0]);
    end
  end

  // Readiness depends only on the pre-pop full flag, so a pop from a full
  // FIFO cannot let a push through in the same cycle.
  assign w_in_ready = ~w_full & {NUM_CORES{~rst}};
  assign w_push     = bus.in_valid & w_in_ready;

  // Round-robin search starting at r_ptr; index arithmetic wraps naturally
  // because NUM_CORES is a power of two.
  always_comb begin
    logic [CW-1:0] idx;
    idx     = '0;
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = r_ptr + CW'(i);
      if (!w_found && !w_empty[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
    end
  end

  assign w_load = !r_out_valid || bus.out_ready;
  assign w_head = r_mem[w_win][r_rptr[w_win][AW-1:0]];

  always_comb begin
    w_stamped      = w_head;
    w_stamped[1:0] = 2'(w_win);
    w_grant        = '0;
    w_grant[w_win] = 1'b1;
    w_pop          = '0;
    if (w_load && w_found) begin
      w_pop[w_win] = 1'b1;
    end
  end

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CORES; k++) begin
      if (w_push[k]) begin
        r_mem[k][r_wptr[k][AW-1:0]] <= bus.in_req[k*REQ_W +: REQ_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        r_wptr[k] <= '0;
        r_rptr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        if (w_push[k]) r_wptr[k] <= r_wptr[k] + (AW+1)'(1);
        if (w_pop[k])  r_rptr[k] <= r_rptr[k] + (AW+1)'(1);
      end
    end
  end

  // Output register stage: loads when empty or being consumed, holds on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_req   <= '0;
      r_out_grant <= '0;
      r_ptr       <= '0;
    end else if (w_load) begin
      if (w_found) begin
        r_out_valid <= 1'b1;
        r_out_req   <= w_stamped;
        r_out_grant <= w_grant;
        r_ptr       <= w_win + CW'(1);
      end else begin
        r_out_valid <= 1'b0;
        r_out_grant <= '0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.fifo_full = w_full;
  assign bus.out_valid = r_out_valid;
  assign bus.out_req   = r_out_req;
  assign bus.out_grant = r_out_grant;

endmodule
